// File: rtl/btn_conditioner_pkg.sv
// btn_pkg: shared types and constants for the button conditioner.
// Optional feature macro: BTN_AUTOREPEAT_EN (see btn_debounce_chan).
package btn_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } btn_state_t;

  // Channel index of each physical button
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  // Signed axis command: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0
  typedef logic signed [1:0] dir_t;

  // Resolve one axis from its positive and negative buttons; both or neither gives 0
  function automatic dir_t axis_resolve(input logic pos, input logic neg);
    dir_t d;
    case ({pos, neg})
      2'b10:   d = 2'sb01;
      2'b01:   d = 2'sb11;
      default: d = 2'sb00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button pins in, conditioned levels/pulses/axes out.
// master = the side driving the pins, slave = the conditioner itself.
interface btn_conditioner_if
  import btn_pkg::*;
#(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  dir_t               dir_x;
  dir_t               dir_y;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, dir_x, dir_y
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, dir_x, dir_y
  );
endinterface

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: one button bit -> 2-flop synchroniser, counter debouncer,
// press/release pulse generator. With BTN_AUTOREPEAT_EN defined, a held
// button also re-pulses press after REPEAT_DELAY and then every REPEAT_PERIOD.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE       = IDLE;
  localparam logic [1:0] ST_PRESS_PEND = PRESS_PEND;
  localparam logic [1:0] ST_HELD       = HELD;
  localparam logic [1:0] ST_REL_PEND   = REL_PEND;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce_chan: DEBOUNCE_CYCLES must be >= 2");
  end

  logic             sync_meta;
  logic             sync;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rep_fire;

  // Two-flop synchroniser; the second flop is the only copy the FSM sees
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  // Debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= rep_fire;
      release_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync) begin
            state <= ST_PRESS_PEND;
            cnt   <= CNT_ONE;
          end
        end
        ST_PRESS_PEND: begin
          if (!sync) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_HELD;
            cnt         <= '0;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!sync) begin
            state <= ST_REL_PEND;
            cnt   <= CNT_ONE;
          end
        end
        ST_REL_PEND: begin
          if (sync) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign level = (state == ST_HELD) || (state == ST_REL_PEND);

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_phase;
  logic [REP_W-1:0] rep_target;

  assign rep_target = rep_phase ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
  assign rep_fire   = (state == ST_HELD) && sync && (rep_cnt == rep_target);

  // Repeat timer: runs while stably held, freezes through a release glitch, clears once idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if ((state == ST_IDLE) || (state == ST_PRESS_PEND)) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if ((state == ST_HELD) && sync) begin
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions the left/right/up/down buttons and resolves
// them into registered signed axis commands for the physics stage.
// Optional feature macro: BTN_AUTOREPEAT_EN (held-button press auto-repeat).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000
`endif
) (
  input logic              clk,
  input logic              reset,
  btn_conditioner_if.slave bus
);

  if (NUM_BTN < 4) begin : g_bad_num_btn
    $error("btn_conditioner: NUM_BTN must cover left/right/up/down");
  end

  logic [NUM_BTN-1:0] level_vec;
  logic [NUM_BTN-1:0] press_vec;
  logic [NUM_BTN-1:0] release_vec;
  dir_t               dir_x_q;
  dir_t               dir_y_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .raw          (bus.btn_raw[i]),
      .level        (level_vec[i]),
      .press_pulse  (press_vec[i]),
      .release_pulse(release_vec[i])
    );
  end

  // Axis resolve register: opposing buttons cancel, result lags btn_level by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_x_q <= 2'sb00;
      dir_y_q <= 2'sb00;
    end else begin
      dir_x_q <= axis_resolve(level_vec[BTN_RIGHT], level_vec[BTN_LEFT]);
      dir_y_q <= axis_resolve(level_vec[BTN_UP], level_vec[BTN_DOWN]);
    end
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;
  assign bus.dir_x       = dir_x_q;
  assign bus.dir_y       = dir_y_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed vectors for btn_conditioner with DEBOUNCE_CYCLES=8,
// so a clean input change shows up on level/pulse 10 edges later.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int NB  = 4;
  localparam int DEB = 8;
`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_DELAY  = 20;
  localparam int REP_PERIOD = 5;
`endif

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   error_count = 0;
  int   press_seen[NB];
  int   release_seen[NB];
  int   snap_press;
  int   snap_release;
  logic exp_bit;

  btn_conditioner_if #(.NUM_BTN(NB)) bus ();

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (REP_DELAY),
    .REPEAT_PERIOD  (REP_PERIOD)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge so whole-window pulse totals can be checked
  initial begin
    for (int i = 0; i < NB; i++) begin
      press_seen[i]   = 0;
      release_seen[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (bus.btn_press[i])   press_seen[i]   <= press_seen[i] + 1;
      if (bus.btn_release[i]) release_seen[i] <= release_seen[i] + 1;
    end
  end

  // Drive the raw pins
  task automatic applyStimulus(input logic [NB-1:0] raw);
    bus.btn_raw = raw;
  endtask

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " level"},   {28'd0, bus.btn_level},   32'd0);
    checkOutput({tag, " press"},   {28'd0, bus.btn_press},   32'd0);
    checkOutput({tag, " release"}, {28'd0, bus.btn_release}, 32'd0);
    checkOutput({tag, " dir_x"},   {30'd0, bus.dir_x},       32'd0);
    checkOutput({tag, " dir_y"},   {30'd0, bus.dir_y},       32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000);
    tick(3);
    checkAllZero("reset");
    reset = 1'b0;
    tick(2);
    checkAllZero("post_reset");

    $display("[TB] test 1: clean left press");
    applyStimulus(4'b0001);
    tick(9);
    checkOutput("t1 press early", {28'd0, bus.btn_press}, 32'd0);
    checkOutput("t1 level early", {28'd0, bus.btn_level}, 32'd0);
    tick(1);
    checkOutput("t1 press",       {28'd0, bus.btn_press}, 32'h1);
    checkOutput("t1 level",       {28'd0, bus.btn_level}, 32'h1);
    checkOutput("t1 dir_x lag",   {30'd0, bus.dir_x},     32'd0);
    snap_press = press_seen[0];
    tick(1);
    checkOutput("t1 press single", {28'd0, bus.btn_press}, 32'd0);
    checkOutput("t1 dir_x",        {30'd0, bus.dir_x},     32'h3);
    tick(8);
    checkOutput("t1 press count", press_seen[0] - snap_press, 32'd1);
    applyStimulus(4'b0000);
    tick(10);
    checkOutput("t1 release", {28'd0, bus.btn_release}, 32'h1);
    checkOutput("t1 level off", {28'd0, bus.btn_level}, 32'd0);
    tick(1);
    checkOutput("t1 dir_x off", {30'd0, bus.dir_x}, 32'd0);
    tick(3);

    $display("[TB] test 2: right bounce rejected");
    snap_press = press_seen[1];
    applyStimulus(4'b0010);
    tick(5);
    applyStimulus(4'b0000);
    tick(15);
    checkOutput("t2 press count", press_seen[1] - snap_press, 32'd0);
    checkOutput("t2 level",       {28'd0, bus.btn_level},     32'd0);

    $display("[TB] test 3: left+right conflict");
    applyStimulus(4'b0011);
    tick(10);
    checkOutput("t3 press both", {28'd0, bus.btn_press}, 32'h3);
    checkOutput("t3 level both", {28'd0, bus.btn_level}, 32'h3);
    tick(1);
    checkOutput("t3 dir_x both", {30'd0, bus.dir_x}, 32'd0);
    tick(9);
    applyStimulus(4'b0001);
    tick(9);
    checkOutput("t3 release early", {28'd0, bus.btn_release}, 32'd0);
    tick(1);
    checkOutput("t3 release right", {28'd0, bus.btn_release}, 32'h2);
    checkOutput("t3 level left",    {28'd0, bus.btn_level},   32'h1);
    checkOutput("t3 dir_x lag",     {30'd0, bus.dir_x},       32'd0);
    tick(1);
    checkOutput("t3 dir_x left",    {30'd0, bus.dir_x},       32'h3);
    applyStimulus(4'b0000);
    tick(10);
    checkOutput("t3 release left",  {28'd0, bus.btn_release}, 32'h1);
    tick(3);

    $display("[TB] test 4: reset during up hold");
    applyStimulus(4'b0100);
    tick(10);
    checkOutput("t4 press up", {28'd0, bus.btn_press}, 32'h4);
    tick(1);
    checkOutput("t4 dir_y up", {30'd0, bus.dir_y}, 32'h1);
    tick(5);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("t4 async reset");
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("t4 in reset");
    snap_press   = press_seen[2];
    snap_release = release_seen[2];
    reset = 1'b0;
    tick(9);
    checkOutput("t4 press early", {28'd0, bus.btn_press}, 32'd0);
    checkOutput("t4 level early", {28'd0, bus.btn_level}, 32'd0);
    tick(1);
    checkOutput("t4 press requal", {28'd0, bus.btn_press}, 32'h4);
    checkOutput("t4 level requal", {28'd0, bus.btn_level}, 32'h4);
    tick(2);
    checkOutput("t4 press count",   press_seen[2] - snap_press,     32'd1);
    checkOutput("t4 release count", release_seen[2] - snap_release, 32'd0);
    applyStimulus(4'b0000);
    tick(12);
    checkOutput("t4 level off", {28'd0, bus.btn_level}, 32'd0);
    tick(2);

    $display("[TB] test 5: down hold with glitch");
    applyStimulus(4'b1000);
    tick(10);
    checkOutput("t5 press down", {28'd0, bus.btn_press}, 32'h8);
    tick(1);
    checkOutput("t5 dir_y down", {30'd0, bus.dir_y}, 32'h3);
    tick(19);
    snap_press   = press_seen[3];
    snap_release = release_seen[3];
    applyStimulus(4'b0000);
    tick(1);
    applyStimulus(4'b1000);
    tick(3);
    checkOutput("t5 level glitch", {28'd0, bus.btn_level}, 32'h8);
    tick(12);
    checkOutput("t5 level after",  {28'd0, bus.btn_level}, 32'h8);
    checkOutput("t5 release count", release_seen[3] - snap_release, 32'd0);
`ifndef BTN_AUTOREPEAT_EN
    checkOutput("t5 press count", press_seen[3] - snap_press, 32'd0);
`endif
    applyStimulus(4'b0000);
    tick(12);
    checkOutput("t5 level off", {28'd0, bus.btn_level}, 32'd0);
    tick(2);

    $display("[TB] test 6: long left hold");
    applyStimulus(4'b0001);
    tick(10);
    checkOutput("t6 accept", {28'd0, bus.btn_press}, 32'h1);
    for (int k = 1; k <= 50; k++) begin
      tick(1);
`ifdef BTN_AUTOREPEAT_EN
      exp_bit = (k == REP_DELAY) || ((k > REP_DELAY) && (((k - REP_DELAY) % REP_PERIOD) == 0));
`else
      exp_bit = 1'b0;
`endif
      checkOutput($sformatf("t6 press k=%0d", k), {31'd0, bus.btn_press[0]}, {31'd0, exp_bit});
    end
    applyStimulus(4'b0000);
    tick(12);
    checkOutput("t6 level off", {28'd0, bus.btn_level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Conditions the four raw user buttons (left/right/up/down) before they reach the physics simulator. Each button goes through:
- a 2-flop synchroniser,
- a counter-based debouncer,
- a press/release edge detector.

The block also resolves opposing-direction conflicts into signed axis commands. It sits between the top-level button pins and the physics stage, in the main clk domain.

Parameters:
NUM_BTN, 4, number of button channels; index 0=left, 1=right, 2=up, 3=down.
DEBOUNCE_CYCLES, 250000, consecutive stable synchronised samples required to accept a new level (10 ms at 25 MHz).
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
clk  input  1  main system clock
reset  input  1  asynchronous active-high reset
btn_raw  input  NUM_BTN  raw, unsynchronised button pins, active-high
btn_level  output  NUM_BTN  debounced level per button
btn_press  output  NUM_BTN  one-cycle pulse on accepted 0->1 transition
btn_release  output  NUM_BTN  one-cycle pulse on accepted 1->0 transition
dir_x  output  2  signed: +1 right only, -1 left only, 0 neither/both
dir_y  output  2  signed: +1 up only, -1 down only, 0 neither/both

Behaviour:
- Reset is async assert, sync release by clk. During and after reset:
  - all outputs 0;
  - synchroniser flops 0;
  - counters 0;
  - every channel FSM in IDLE.
- Synchroniser: two flops per bit. sync = second flop.
- Per-channel FSM states: IDLE (level 0), PRESS_PEND, HELD (level 1), REL_PEND.
  - IDLE: sync=1 -> PRESS_PEND, counter <= 1.
  - PRESS_PEND:
    - sync=0 -> IDLE, counter <= 0 (glitch rejected, no pulse).
    - sync=1 and counter==DEBOUNCE_CYCLES-1 -> HELD, counter <= 0, btn_press pulses the same edge the state becomes HELD.
    - otherwise counter+1.
  - HELD: sync=0 -> REL_PEND, counter <= 1.
  - REL_PEND: mirror of PRESS_PEND. Timeout -> IDLE with btn_release pulse. sync=1 -> HELD, no pulse.
- btn_level = 1 in HELD and REL_PEND, 0 in IDLE and PRESS_PEND.
- Latency: a clean press on btn_raw at edge N yields btn_level/btn_press at edge N+2+DEBOUNCE_CYCLES (2 sync + debounce window). Release is symmetric.
- Pulses are exactly one cycle. press and release for the same channel never assert together.
- Counter saturates logically; it never wraps, because the FSM leaves the pending state at the terminal count.
- dir_x, dir_y are registered from btn_level, so one extra cycle after btn_level. Encoding: 2'b01=+1, 2'b11=-1, 2'b00=0. Both opposing buttons held -> 0.
- Reset mid-debounce discards pending state. No pulse is emitted on reset exit, even if btn_raw is held high; the press is re-qualified from IDLE.
- DEBOUNCE_CYCLES must be >=2. Enforce with an elaboration-time assertion.

Optional Feature:
Macro: BTN_AUTOREPEAT_EN.
- Defined: parameters REPEAT_DELAY (default 12500000) and REPEAT_PERIOD (default 2500000) are added.
  - While a channel is in HELD, a per-channel repeat counter runs.
  - btn_press re-pulses after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles.
  - The repeat counter clears on leaving HELD. REL_PEND pauses it; returning to HELD resumes without reset.
- Undefined: no repeat logic. btn_press fires exactly once per accepted press.

Decomposition:
- Package btn_pkg:
  - enum btn_state_t {IDLE, PRESS_PEND, HELD, REL_PEND};
  - localparams BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3;
  - typedef dir_t (logic signed [1:0]).
- One sub-module, btn_debounce_chan: synchroniser + FSM + counter (+ repeat counter) for a single bit, instantiated NUM_BTN times via generate.
- The top handles the dir_x/dir_y resolve register.

Test Plan (DEBOUNCE_CYCLES=8 for sim; REPEAT_DELAY=20, REPEAT_PERIOD=5 when enabled):
1. btn_raw[0] 0->1 held 20 cycles -> btn_press[0] single pulse 10 cycles after input edge; btn_level[0]=1; dir_x=2'b11 one cycle later.
2. btn_raw[1] high for 5 cycles then low (bounce) -> no btn_press[1]; btn_level[1] stays 0.
3. Press left and right (both stable 20 cycles) -> btn_level=4'b0011, dir_x=0. Release right -> btn_release[1] after 10 cycles, dir_x=2'b11 next cycle.
4. Hold up, assert reset for 3 cycles mid-hold -> all outputs 0 asynchronously. After release, btn_press[2] fires 10 cycles later with no release pulse in between.
5. Held down with 1-cycle low glitch at cycle 30 -> btn_level[3] stays 1, no btn_release, no second btn_press.
6. BTN_AUTOREPEAT_EN defined, hold left 50 cycles post-accept -> btn_press[0] at accept, +20, +25, +30, ... Undefined -> single pulse only.
